// File: rtl/keccak_result_collector.sv
// keccak_result_collector: captures the digest words produced by the Keccak core,
// frames each test with a header word, stores everything in a result memory and
// tracks how many tests have completed. A registered read port lets the host dump
// the collected results after the run.
module keccak_result_collector #(
    parameter int DATA_LENGTH = 64,
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_test,
    input  logic [2:0]             cmode,
    input  logic [10:0]            d,
    input  logic [10:0]            no_test,
    input  logic                   dout_valid,
    input  logic [DATA_LENGTH-1:0] dout,
    output logic                   dout_ready,
    input  logic                   finish_hash,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [DATA_LENGTH-1:0] rd_data,
    output logic [ADDR_W:0]        wr_ptr,
    output logic [10:0]            test_count,
    output logic                   digest_done,
    output logic                   all_done,
    output logic                   overflow,
    output logic                   short_err
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT_FIN,
        DONE,
        FULL
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);

    logic [DATA_LENGTH-1:0] mem [MEM_SIZE];

    state_t                 state_q, state_d;
    logic [7:0]             remain_q, remain_d;
    logic [6:0]             lastBits_q, lastBits_d;
    logic [ADDR_W:0]        wrPtr_q, wrPtr_d;
    logic [10:0]            testCount_q, testCount_d;
    logic                   digestDone_q, digestDone_d;
    logic                   overflow_q, overflow_d;
    logic                   shortErr_q, shortErr_d;
    logic                   finishHash_q;
    logic [DATA_LENGTH-1:0] rdData_q;

    logic [11:0]            shakeSum;
    logic [7:0]             startWords;
    logic [6:0]             startBits;
    logic [DATA_LENGTH-1:0] headerWord;
    logic [DATA_LENGTH-1:0] lastMask;
    logic [DATA_LENGTH-1:0] maskedWord;
    logic                   finishRise;
    logic                   memFull;
    logic                   accept;
    logic [10:0]            countNext;
    logic [7:0]             remAfter;
    logic                   memWe;
    logic [ADDR_W-1:0]      memAddr;
    logic [DATA_LENGTH-1:0] memData;

    assign finishRise = finish_hash && !finishHash_q;
    assign memFull    = (wrPtr_q == MEM_LIMIT);
    assign dout_ready = (state_q == CAPTURE) || (state_q == FULL);
    assign accept     = dout_valid && dout_ready;
    assign countNext  = testCount_q + 11'd1;

    // Digest length in words and valid bits of the final word for the requested mode.
    always_comb begin
        shakeSum   = {1'b0, d} + 12'd63;
        startWords = 8'd0;
        startBits  = 7'd64;
        case (cmode)
            3'd0: begin
                startWords = 8'd4;
                startBits  = 7'd32;
            end
            3'd1: startWords = 8'd4;
            3'd2: startWords = 8'd6;
            3'd3: startWords = 8'd8;
            3'd4, 3'd5: begin
                startWords = {2'b00, shakeSum[11:6]};
                startBits  = (d[5:0] == 6'd0) ? 7'd64 : {1'b0, d[5:0]};
            end
            default: begin
                startWords = 8'd0;
                startBits  = 7'd64;
            end
        endcase
    end

    // Header framing and truncation of the final word to its valid leading bits.
    always_comb begin
        headerWord = {16'hC0DE, 5'd0, testCount_q, 5'd0, cmode, 5'd0, d, startWords};
        lastMask   = (lastBits_q == 7'd64) ? {DATA_LENGTH{1'b1}}
                                           : ~({DATA_LENGTH{1'b1}} >> lastBits_q);
        maskedWord = (remain_q == 8'd1) ? (dout & lastMask) : dout;
    end

    // Next-state logic: framing, capture, test completion and overflow handling.
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        lastBits_d   = lastBits_q;
        wrPtr_d      = wrPtr_q;
        testCount_d  = testCount_q;
        digestDone_d = 1'b0;
        overflow_d   = overflow_q;
        shortErr_d   = shortErr_q;
        remAfter     = remain_q - {7'd0, accept};
        memWe        = 1'b0;
        memAddr      = wrPtr_q[ADDR_W-1:0];
        memData      = maskedWord;
        case (state_q)
            IDLE: begin
                if (testCount_q == no_test) begin
                    state_d = DONE;
                end else if (start_test) begin
                    if (memFull) begin
                        overflow_d = 1'b1;
                        state_d    = FULL;
                    end else begin
                        memWe      = 1'b1;
                        memData    = headerWord;
                        wrPtr_d    = wrPtr_q + 1'b1;
                        remain_d   = startWords;
                        lastBits_d = startBits;
                        state_d    = (startWords == 8'd0) ? WAIT_FIN : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                remain_d = remAfter;
                if (accept) begin
                    if (memFull) begin
                        overflow_d = 1'b1;
                    end else begin
                        memWe   = 1'b1;
                        wrPtr_d = wrPtr_q + 1'b1;
                    end
                end
                if (finishRise) begin
                    testCount_d  = countNext;
                    digestDone_d = 1'b1;
                    if (remAfter != 8'd0) begin
                        shortErr_d = 1'b1;
                    end
                end
                if (accept && memFull) begin
                    state_d = FULL;
                end else if (finishRise) begin
                    state_d = (countNext == no_test) ? DONE : IDLE;
                end else if (remAfter == 8'd0) begin
                    state_d = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (finishRise) begin
                    testCount_d  = countNext;
                    digestDone_d = 1'b1;
                    state_d      = (countNext == no_test) ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            FULL: begin
                if (finishRise) begin
                    testCount_d  = countNext;
                    digestDone_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remain_q     <= 8'd0;
            lastBits_q   <= 7'd64;
            wrPtr_q      <= '0;
            testCount_q  <= 11'd0;
            digestDone_q <= 1'b0;
            overflow_q   <= 1'b0;
            shortErr_q   <= 1'b0;
            finishHash_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            lastBits_q   <= lastBits_d;
            wrPtr_q      <= wrPtr_d;
            testCount_q  <= testCount_d;
            digestDone_q <= digestDone_d;
            overflow_q   <= overflow_d;
            shortErr_q   <= shortErr_d;
            finishHash_q <= finish_hash;
        end
    end

    // Result memory write port; no writes while held in reset.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[memAddr] <= memData;
        end
    end

    // Registered read port; a same-cycle write to the address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if ({1'b0, rd_addr} < MEM_LIMIT) begin
            rdData_q <= mem[rd_addr];
        end else begin
            rdData_q <= '0;
        end
    end

    assign rd_data     = rdData_q;
    assign wr_ptr      = wrPtr_q;
    assign test_count  = testCount_q;
    assign digest_done = digestDone_q;
    assign overflow    = overflow_q;
    assign short_err   = shortErr_q;
    assign all_done    = (state_q == DONE) ||
                         ((state_q == FULL) && (testCount_q == no_test));

endmodule

// File: tb/tb_keccak_result_collector.sv
// Testbench for keccak_result_collector: a table of digest tests is replayed
// against a full-size instance, expected memory contents go into a scoreboard
// queue as words are driven and are compared when the memory is dumped. A second
// instance with an 8-word memory exercises the overflow path.
module tb_keccak_result_collector;

    localparam logic [63:0] ONES = {64{1'b1}};

    typedef struct {
        logic [2:0]  cmode;
        logic [10:0] dLen;
        int          sendWords;
        int          expWords;
        logic [63:0] base;
        logic [63:0] lastMask;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
    } sbEntry_t;

    logic        clk;
    logic        rstMain;
    logic        rstSmall;
    logic        startTest;
    logic [2:0]  cmodeIn;
    logic [10:0] dIn;
    logic [10:0] noTest;
    logic        doutValid;
    logic [63:0] doutIn;
    logic        finishHash;
    logic [9:0]  rdAddr;

    logic        readyM, digestDoneM, allDoneM, overflowM, shortErrM;
    logic [63:0] rdDataM;
    logic [10:0] wrPtrM;
    logic [10:0] testCountM;

    logic        readyS, digestDoneS, allDoneS, overflowS, shortErrS;
    logic [63:0] rdDataS;
    logic [3:0]  wrPtrS;
    logic [10:0] testCountS;

    int          checkCount;
    int          passCount;
    int          modelPtr;
    vec_t        vecs [10];
    sbEntry_t    sbQueue [$];

    keccak_result_collector dutMain (
        .clk        (clk),
        .rst        (rstMain),
        .start_test (startTest),
        .cmode      (cmodeIn),
        .d          (dIn),
        .no_test    (noTest),
        .dout_valid (doutValid),
        .dout       (doutIn),
        .dout_ready (readyM),
        .finish_hash(finishHash),
        .rd_addr    (rdAddr),
        .rd_data    (rdDataM),
        .wr_ptr     (wrPtrM),
        .test_count (testCountM),
        .digest_done(digestDoneM),
        .all_done   (allDoneM),
        .overflow   (overflowM),
        .short_err  (shortErrM)
    );

    keccak_result_collector #(
        .DATA_LENGTH(64),
        .MEM_SIZE   (8),
        .ADDR_W     (3)
    ) dutSmall (
        .clk        (clk),
        .rst        (rstSmall),
        .start_test (startTest),
        .cmode      (cmodeIn),
        .d          (dIn),
        .no_test    (noTest),
        .dout_valid (doutValid),
        .dout       (doutIn),
        .dout_ready (readyS),
        .finish_hash(finishHash),
        .rd_addr    (rdAddr[2:0]),
        .rd_data    (rdDataS),
        .wr_ptr     (wrPtrS),
        .test_count (testCountS),
        .digest_done(digestDoneS),
        .all_done   (allDoneS),
        .overflow   (overflowS),
        .short_err  (shortErrS)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int addr, input logic [63:0] data);
        sbEntry_t e;
        e.addr = 10'(addr);
        e.data = data;
        sbQueue.push_back(e);
    endtask

    task automatic dumpAndCheck();
        sbEntry_t e;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            rdAddr = e.addr;
            tick();
            checkOutput($sformatf("mem[%0d]", e.addr), rdDataM, e.data);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int testIdx);
        logic [63:0] hdr;
        logic [63:0] word;
        hdr = {16'hC0DE, 5'd0, 11'(testIdx), 5'd0, v.cmode, 5'd0, v.dLen, 8'(v.expWords)};
        startTest = 1'b1;
        cmodeIn   = v.cmode;
        dIn       = v.dLen;
        pushExpected(modelPtr, hdr);
        modelPtr++;
        tick();
        startTest = 1'b0;
        if (v.expWords == 0) begin
            checkOutput($sformatf("t%0d ready_after_empty_hdr", testIdx), 64'(readyM), 64'd0);
        end
        for (int k = 0; k < v.sendWords; k++) begin
            doutValid = 1'b1;
            doutIn    = v.base + 64'(k);
            if (k == 0) begin
                checkOutput($sformatf("t%0d ready_capture", testIdx), 64'(readyM), 64'd1);
            end
            word = (k == v.expWords - 1) ? (doutIn & v.lastMask) : doutIn;
            pushExpected(modelPtr, word);
            modelPtr++;
            tick();
        end
        doutValid  = 1'b0;
        finishHash = 1'b1;
        tick();
        checkOutput($sformatf("t%0d digest_done", testIdx), 64'(digestDoneM), 64'd1);
        checkOutput($sformatf("t%0d test_count", testIdx), 64'(testCountM), 64'(testIdx + 1));
        checkOutput($sformatf("t%0d short_err", testIdx), 64'(shortErrM),
                    64'(v.sendWords < v.expWords));
        if (v.sendWords < v.expWords) begin
            checkOutput($sformatf("t%0d ready_after_short", testIdx), 64'(readyM), 64'd0);
        end
        finishHash = 1'b0;
        tick();
        checkOutput($sformatf("t%0d digest_pulse_end", testIdx), 64'(digestDoneM), 64'd0);
        checkOutput($sformatf("t%0d wr_ptr", testIdx), 64'(wrPtrM), 64'(modelPtr));
    endtask

    // Main sequence: reset, table of tests, corner-case sequences, summary.
    initial begin
        checkCount = 0;
        passCount  = 0;
        modelPtr   = 0;

        vecs[0] = '{cmode: 3'd1, dLen: 11'd0,    sendWords: 4,  expWords: 4,
                    base: 64'd1,                   lastMask: ONES};
        vecs[1] = '{cmode: 3'd0, dLen: 11'd0,    sendWords: 4,  expWords: 4,
                    base: 64'hFFFF_FFFF_FFFF_FFFC, lastMask: 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{cmode: 3'd4, dLen: 11'd65,   sendWords: 2,  expWords: 2,
                    base: 64'hFFFF_FFFF_FFFF_FFFE, lastMask: 64'h8000_0000_0000_0000};
        vecs[3] = '{cmode: 3'd5, dLen: 11'd2047, sendWords: 32, expWords: 32,
                    base: 64'h0123_4567_89AB_CDF0, lastMask: 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{cmode: 3'd2, dLen: 11'd0,    sendWords: 6,  expWords: 6,
                    base: 64'hA5A5_0000_0000_0000, lastMask: ONES};
        vecs[5] = '{cmode: 3'd3, dLen: 11'd0,    sendWords: 8,  expWords: 8,
                    base: 64'h0000_0000_0000_1000, lastMask: ONES};
        vecs[6] = '{cmode: 3'd4, dLen: 11'd0,    sendWords: 0,  expWords: 0,
                    base: 64'd0,                   lastMask: ONES};
        vecs[7] = '{cmode: 3'd6, dLen: 11'd5,    sendWords: 0,  expWords: 0,
                    base: 64'd0,                   lastMask: ONES};
        vecs[8] = '{cmode: 3'd4, dLen: 11'd128,  sendWords: 2,  expWords: 2,
                    base: 64'hDEAD_BEEF_0000_0001, lastMask: ONES};
        vecs[9] = '{cmode: 3'd3, dLen: 11'd0,    sendWords: 2,  expWords: 8,
                    base: 64'h0000_0000_0000_7777, lastMask: ONES};

        rstMain    = 1'b1;
        rstSmall   = 1'b1;
        startTest  = 1'b0;
        cmodeIn    = 3'd0;
        dIn        = 11'd0;
        noTest     = 11'd100;
        doutValid  = 1'b0;
        doutIn     = 64'd0;
        finishHash = 1'b0;
        rdAddr     = 10'd0;
        tick();
        tick();
        $display("[TB] checking reset state");
        checkOutput("rst dout_ready", 64'(readyM), 64'd0);
        checkOutput("rst rd_data", rdDataM, 64'd0);
        checkOutput("rst wr_ptr", 64'(wrPtrM), 64'd0);
        checkOutput("rst test_count", 64'(testCountM), 64'd0);
        checkOutput("rst digest_done", 64'(digestDoneM), 64'd0);
        checkOutput("rst all_done", 64'(allDoneM), 64'd0);
        checkOutput("rst overflow", 64'(overflowM), 64'd0);
        checkOutput("rst short_err", 64'(shortErrM), 64'd0);
        rstMain = 1'b0;

        $display("[TB] running table of digest tests");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // A finish_hash rise while idle must not count as a test.
        finishHash = 1'b1;
        tick();
        checkOutput("idle_finish digest_done", 64'(digestDoneM), 64'd0);
        checkOutput("idle_finish test_count", 64'(testCountM), 64'd10);
        finishHash = 1'b0;
        tick();
        dumpAndCheck();

        $display("[TB] back-to-back tests with start_test held high");
        rstMain = 1'b1;
        tick();
        tick();
        noTest    = 11'd2;
        startTest = 1'b1;
        cmodeIn   = 3'd1;
        dIn       = 11'd0;
        rstMain   = 1'b0;
        modelPtr  = 0;
        for (int t = 0; t < 2; t++) begin
            finishHash = 1'b0;
            pushExpected(modelPtr, {16'hC0DE, 5'd0, 11'(t), 5'd0, 3'd1, 5'd0, 11'd0, 8'd4});
            modelPtr++;
            tick();
            for (int k = 0; k < 4; k++) begin
                doutValid = 1'b1;
                doutIn    = 64'h100 * 64'(t + 1) + 64'(k);
                pushExpected(modelPtr, doutIn);
                modelPtr++;
                tick();
            end
            doutValid  = 1'b0;
            finishHash = 1'b1;
            tick();
            checkOutput($sformatf("b2b%0d digest_done", t), 64'(digestDoneM), 64'd1);
            checkOutput($sformatf("b2b%0d all_done", t), 64'(allDoneM), 64'(t == 1));
            checkOutput($sformatf("b2b%0d test_count", t), 64'(testCountM), 64'(t + 1));
        end
        finishHash = 1'b0;
        doutValid  = 1'b1;
        doutIn     = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("done ready", 64'(readyM), 64'd0);
        end
        checkOutput("done all_done", 64'(allDoneM), 64'd1);
        checkOutput("done wr_ptr", 64'(wrPtrM), 64'd10);
        checkOutput("done test_count", 64'(testCountM), 64'd2);
        doutValid = 1'b0;
        startTest = 1'b0;
        dumpAndCheck();

        $display("[TB] no_test of zero");
        rstMain = 1'b1;
        tick();
        noTest    = 11'd0;
        rstMain   = 1'b0;
        startTest = 1'b1;
        tick();
        tick();
        checkOutput("zero all_done", 64'(allDoneM), 64'd1);
        checkOutput("zero wr_ptr", 64'(wrPtrM), 64'd0);
        checkOutput("zero ready", 64'(readyM), 64'd0);
        startTest = 1'b0;

        $display("[TB] overflow on the 8-word instance");
        rstMain   = 1'b1;
        noTest    = 11'd100;
        cmodeIn   = 3'd3;
        dIn       = 11'd0;
        startTest = 1'b1;
        rstSmall  = 1'b0;
        tick();
        startTest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            doutValid = 1'b1;
            doutIn    = 64'h5000 + 64'(k);
            tick();
            if (k == 6) begin
                checkOutput("small wr_ptr_at_limit", 64'(wrPtrS), 64'd8);
                checkOutput("small overflow_before", 64'(overflowS), 64'd0);
            end
        end
        checkOutput("small overflow", 64'(overflowS), 64'd1);
        checkOutput("small ready_full", 64'(readyS), 64'd1);
        for (int k = 0; k < 3; k++) begin
            doutIn = 64'h6000 + 64'(k);
            tick();
        end
        checkOutput("small wr_ptr_held", 64'(wrPtrS), 64'd8);
        checkOutput("small ready_still", 64'(readyS), 64'd1);
        doutValid = 1'b0;
        rdAddr    = 10'd7;
        tick();
        tick();
        checkOutput("small mem[7]", rdDataS, 64'h5006);
        finishHash = 1'b1;
        tick();
        checkOutput("small full_count", 64'(testCountS), 64'd1);
        checkOutput("small full_digest", 64'(digestDoneS), 64'd1);
        finishHash = 1'b0;
        rstSmall   = 1'b1;
        tick();
        checkOutput("small rst overflow", 64'(overflowS), 64'd0);
        checkOutput("small rst wr_ptr", 64'(wrPtrS), 64'd0);
        checkOutput("small rst ready", 64'(readyS), 64'd0);
        checkOutput("small rst test_count", 64'(testCountS), 64'd0);
        checkOutput("small rst short_err", 64'(shortErrS), 64'd0);
        checkOutput("small rst all_done", 64'(allDoneS), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/keccak_result_collector.md
# keccak_result_collector

Output-side companion of the Keccak test-vector reader: where the reader feeds cmode, d and 64-bit message words into the Keccak core, this block captures the digest words the core emits. It frames each test's digest with a header word, stores it in an internal result memory, counts completed tests against the expected test total, and exposes a registered read port so the bench or host can dump results after the run. It sits between the Keccak core output and the bench or host.

## Interface
- DATA_LENGTH, 64, digest word width
- MEM_SIZE, 1024, result memory depth in words
- ADDR_W, 10, result memory address width (must satisfy 2^ADDR_W >= MEM_SIZE)

- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start_test  input  1  level; begin a test (sampled only in IDLE)
- cmode  input  3  hash mode, sampled with start_test
- d  input  11  SHAKE output length in bits, sampled with start_test
- no_test  input  11  total tests expected in the run
- dout_valid  input  1  core digest word valid
- dout  input  64  core digest word
- dout_ready  output  1  collector accepts a digest word this cycle
- finish_hash  input  1  core done level; the rising edge ends the current test
- rd_addr  input  ADDR_W  result memory read address
- rd_data  output  64  registered read data
- wr_ptr  output  ADDR_W+1  words written so far
- test_count  output  11  completed tests
- digest_done  output  1  one-cycle pulse per completed test
- all_done  output  1  test_count has reached no_test
- overflow  output  1  sticky; memory full, words dropped
- short_err  output  1  sticky; finish_hash rose before the digest was complete

## Operation
- Word count nwords (8 bits), fixed at start_test:
  - cmode 0 SHA3-224: 4 words, 224 bits.
  - cmode 1 SHA3-256: 4 words, 256 bits.
  - cmode 2 SHA3-384: 6 words, 384 bits.
  - cmode 3 SHA3-512: 8 words, 512 bits.
  - cmode 4/5 SHAKE128/256: (d+63)>>6 words, d bits; compute in 12 bits, so d=2047 gives 32 words and d=0 gives 0 words.
  - cmode 6/7: 0 words.
- Partial last word: with r = valid bits in the final word (nonzero), store dout[63 -: r] and zero the lower bits. SHA3-224 word 3 stores {dout[63:32], 32'h0}.
- Header word: [63:48]=16'hC0DE, [42:32]=test_count, [26:24]=cmode, [18:8]=d, [7:0]=nwords, all other bits 0.
- FSM states:
  - IDLE: dout_ready=0. If start_test, latch cmode/d, write header at wr_ptr, go to CAPTURE (or WAIT_FIN if nwords=0).
  - CAPTURE: dout_ready=1. Each dout_valid&&dout_ready writes a masked word and decrements the remaining count. When the remaining count reaches 0, go to WAIT_FIN.
  - WAIT_FIN: dout_ready=0. On a finish_hash rise, increment test_count and pulse digest_done. Go to DONE if the new count equals no_test, else IDLE.
  - DONE: all_done=1, dout_ready=0, start_test ignored. Exit only via rst.
  - FULL: entered whenever a write is attempted with wr_ptr==MEM_SIZE. Sets overflow; dout_ready=1 and all words are discarded; finish_hash rises still count tests. Exit only via rst.
- Rise detect: a finish_hash rise is finish_hash && !finish_hash_q. finish_hash_q is registered and resets to 0.
- finish_hash rise in CAPTURE with words remaining: set short_err, count the test, pulse digest_done, no padding, go to IDLE or DONE. A word accepted in that same cycle is still written.
- finish_hash rise in IDLE: ignored, not counted.
- no_test=0: go IDLE→DONE the first cycle after rst deasserts.
- Read port: read-first. A same-cycle write to rd_addr returns the old contents.

## Timing
- Reset values: dout_ready 0, rd_data 0, wr_ptr 0, test_count 0, digest_done 0, all_done 0, overflow 0, short_err 0; state IDLE.
- Header is written on the start_test cycle. CAPTURE and dout_ready=1 follow in the next cycle.
- A word accepted in cycle N is readable via rd_addr from cycle N+1; wr_ptr increments in N+1.
- rd_data is valid one cycle after rd_addr.
- Minimum test length: 1 header cycle + nwords cycles + 1 finish cycle.
- digest_done is high in the cycle after the finish_hash rise. all_done rises in the same cycle as the final digest_done.
- start_test held high continuously is legal; the next test starts on the cycle IDLE is re-entered.

## Test plan
- SHA3-256 (cmode 1), four words 1..4, then a finish_hash rise -> mem[0]=C0DE_0000_0100_0004, mem[1..4]=1..4, test_count=1, wr_ptr=5.
- SHA3-224 (cmode 0), last word FFFF_FFFF_FFFF_FFFF -> stored FFFF_FFFF_0000_0000; header nwords=4.
- SHAKE128 (cmode 4), d=65 -> nwords=2, word 1 stored as 8000_0000_0000_0000. Also d=0 -> header only, then WAIT_FIN.
- finish_hash rises after 2 of 8 SHA3-512 words -> short_err=1, test counted, dout_ready=0 in the next cycle.
- MEM_SIZE=8, SHA3-512 test -> overflow=1 once wr_ptr=8, further words dropped with dout_ready=1, and rst clears all flags.
- no_test=2, two tests run back to back with start_test tied high -> all_done rises with the second digest_done; later start_test and dout_valid are ignored.
